pc_ir_unit: RTL and testbench



---
 rtl/pc_ir_unit_pkg.sv | 29 ++
 rtl/pc_ir_unit_if.sv | 37 +++
 rtl/pc_ir_unit_pc_next.sv | 35 +++
 rtl/pc_ir_unit.sv | 75 +++++++
 tb/tb_pc_ir_unit.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_ir_unit_pkg.sv
// Shared opcode encodings, widths and reset constants
// for the PC / IR datapath stage.
package pc_ir_unit_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 8;
  localparam int CNT_WIDTH  = 16;

  localparam logic [2:0] OPCODE_HLT = 3'd0;
  localparam logic [2:0] OPCODE_SKZ = 3'd1;
  localparam logic [2:0] OPCODE_ADD = 3'd2;
  localparam logic [2:0] OPCODE_AND = 3'd3;
  localparam logic [2:0] OPCODE_XOR = 3'd4;
  localparam logic [2:0] OPCODE_LDA = 3'd5;
  localparam logic [2:0] OPCODE_STO = 3'd6;
  localparam logic [2:0] OPCODE_JMP = 3'd7;

  // Non-HLT reset IR so a fresh core never looks halted.
  localparam logic [DATA_WIDTH-1:0] IR_RESET_VALUE =
    {OPCODE_SKZ, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    INC_HOLD = 2'd0,
    INC_ONE  = 2'd1,
    INC_TWO  = 2'd2,
    INC_BAD  = 2'd3
  } inc_t;

endpackage

// File: rtl/pc_ir_unit_if.sv
// Controller <-> PC/IR stage bundle: strobes and memory read
// data in, address / IR fields / debug state out.
interface pc_ir_if #(
  parameter int AW = 5,
  parameter int DW = 8,
  parameter int CW = 16
);
  logic          sel;
  logic          rd;
  logic          ld_ir;
  logic [1:0]    inc_pc;
  logic          ld_pc;
  logic          halt;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] addr;
  logic [2:0]    opcode;
  logic [AW-1:0] operand;
  logic [AW-1:0] pc;
  logic [AW-1:0] inst_pc;
  logic [CW-1:0] retired;
  logic          halted;
  logic          seq_err;

  modport master (
    output sel, rd, ld_ir, inc_pc,
    output ld_pc, halt, mem_rdata,
    input  addr, opcode, operand, pc,
    input  inst_pc, retired, halted, seq_err
  );

  modport slave (
    input  sel, rd, ld_ir, inc_pc,
    input  ld_pc, halt, mem_rdata,
    output addr, opcode, operand, pc,
    output inst_pc, retired, halted, seq_err
  );
endinterface

// File: rtl/pc_ir_unit_pc_next.sv
// Combinational next-PC: jump beats increment, modulo add,
// flags illegal strobe combinations.
module pc_ir_unit_pc_next
  import pc_ir_unit_pkg::*;
#(
  parameter int AW = ADDR_WIDTH
) (
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] operand,
  input  logic          ld_pc,
  input  logic [1:0]    inc_pc,
  output logic [AW-1:0] pc_nxt,
  output logic          err
);

  inc_t inc;

  assign inc = inc_t'(inc_pc);

  always_comb begin
    pc_nxt = pc;
    err    = 1'b0;
    priority case (1'b1)
      ld_pc: begin
        pc_nxt = operand;
        err    = (inc != INC_HOLD);
      end
      (inc == INC_ONE): pc_nxt = pc + AW'(1);
      (inc == INC_TWO): pc_nxt = pc + AW'(2);
      (inc == INC_BAD): err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_ir_unit.sv
// PC / IR datapath stage: address mux, IR, inst_pc, retire
// counter, sticky halted and seq_err. Ports: clk, rst, bus.
module pc_ir_unit
  import pc_ir_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = DATA_WIDTH,
  parameter int CNT_W  = CNT_WIDTH
) (
  input logic   clk,
  input logic   rst,
  pc_ir_if.slave bus
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inst_pc;
  logic [DATA_W-1:0] ir;
  logic [CNT_W-1:0]  retired;
  logic              halted;
  logic              seq_err;
  logic [ADDR_W-1:0] operand;
  logic [ADDR_W-1:0] pc_nxt;
  logic              pc_err;

  assign operand = ir[ADDR_W-1:0];

  pc_ir_unit_pc_next #(.AW(ADDR_W)) u_pc_next (
    .pc      (pc),
    .operand (operand),
    .ld_pc   (bus.ld_pc),
    .inc_pc  (bus.inc_pc),
    .pc_nxt  (pc_nxt),
    .err     (pc_err)
  );

  // Jump target comes from the pre-load operand since ir is
  // only written at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      inst_pc <= '0;
      ir      <= DATA_W'(IR_RESET_VALUE);
      retired <= '0;
      halted  <= 1'b0;
      seq_err <= 1'b0;
    end else if (!halted) begin
      if (bus.halt) begin
        halted <= 1'b1;
      end else begin
        pc <= pc_nxt;
        if (pc_err)
          seq_err <= 1'b1;
        if (bus.ld_ir) begin
          if (bus.rd) begin
            ir      <= bus.mem_rdata;
            inst_pc <= pc;
            retired <= retired + CNT_W'(1);
          end else begin
            seq_err <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.addr    = bus.sel ? pc : operand;
  assign bus.opcode  = ir[DATA_W-1 -: 3];
  assign bus.operand = operand;
  assign bus.pc      = pc;
  assign bus.inst_pc = inst_pc;
  assign bus.retired = retired;
  assign bus.halted  = halted;
  assign bus.seq_err = seq_err;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: reference model feeds
// an expectation queue, each test pops and compares.
module tb_pc_ir_unit;

  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;

  typedef struct {
    logic [4:0]  pc;
    logic [4:0]  inst_pc;
    logic [7:0]  ir;
    logic [15:0] retired;
    logic        halted;
    logic        seq_err;
  } snap_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  snap_t q[$];
  snap_t e;

  logic [4:0]  m_pc;
  logic [4:0]  m_inst;
  logic [7:0]  m_ir;
  logic [15:0] m_ret;
  logic        m_halt;
  logic        m_err;

  pc_ir_if #(.AW(5), .DW(8), .CW(16)) bus ();

  pc_ir_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; model next state is pushed first.
  task automatic cyc(
    input logic       s,
    input logic       r,
    input logic       li,
    input logic [1:0] ip,
    input logic       lp,
    input logic       h,
    input logic [7:0] md
  );
    logic [4:0] pc0;
    logic [4:0] op0;
    snap_t      sn;
    bus.sel       = s;
    bus.rd        = r;
    bus.ld_ir     = li;
    bus.inc_pc    = ip;
    bus.ld_pc     = lp;
    bus.halt      = h;
    bus.mem_rdata = md;
    pc0 = m_pc;
    op0 = m_ir[4:0];
    if (rst) begin
      m_pc   = 5'd0;
      m_inst = 5'd0;
      m_ir   = {OP_SKZ, 5'd0};
      m_ret  = 16'd0;
      m_halt = 1'b0;
      m_err  = 1'b0;
    end else if (!m_halt) begin
      if (h) begin
        m_halt = 1'b1;
      end else begin
        if (lp) begin
          m_pc = op0;
          if (ip != 2'd0) m_err = 1'b1;
        end else if (ip == 2'd3) begin
          m_err = 1'b1;
        end else begin
          m_pc = 5'((int'(pc0) + int'(ip)) % 32);
        end
        if (li && r) begin
          m_ir   = md;
          m_inst = pc0;
          m_ret  = m_ret + 16'd1;
        end else if (li) begin
          m_err = 1'b1;
        end
      end
    end
    sn.pc      = m_pc;
    sn.inst_pc = m_inst;
    sn.ir      = m_ir;
    sn.retired = m_ret;
    sn.halted  = m_halt;
    sn.seq_err = m_err;
    q.push_back(sn);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);
      void'(q.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  // Load IR with operand t, then jump there.
  task automatic goto_pc(input logic [4:0] t);
    cyc(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, {OP_LDA, t});
    void'(q.pop_front());
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 8'd0);
    void'(q.pop_front());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);
      e = q.pop_front();
    end
    rst = 1'b0;
    checks++;
    if (bus.pc !== 5'd0) begin
      errors++;
      $display("FAIL reset_pc got %0d exp 0", bus.pc);
    end
    checks++;
    if (bus.retired !== 16'd0 || bus.halted !== 1'b0
        || bus.seq_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got %0d/%b/%b exp 0/0/0",
               bus.retired, bus.halted, bus.seq_err);
    end
    checks++;
    if (bus.opcode !== OP_SKZ || bus.inst_pc !== 5'd0) begin
      errors++;
      $display("FAIL reset_ir got op %0d ipc %0d exp %0d 0",
               bus.opcode, bus.inst_pc, OP_SKZ);
    end
    checks++;
    if (bus.addr !== 5'd0) begin
      errors++;
      $display("FAIL reset_addr got %0d exp 0", bus.addr);
    end
  endtask

  task automatic test_fetch();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 8'd0);
      e = q.pop_front();
      checks++;
      if (bus.pc !== e.pc) begin
        errors++;
        $display("FAIL fetch_inc got %0d exp %0d", bus.pc, e.pc);
      end
    end
    cyc(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, {OP_ADD, 5'd17});
    e = q.pop_front();
    checks++;
    if (bus.opcode !== OP_ADD || bus.operand !== 5'd17) begin
      errors++;
      $display("FAIL fetch_ir got %0d/%0d exp %0d/17",
               bus.opcode, bus.operand, OP_ADD);
    end
    checks++;
    if (bus.inst_pc !== 5'd3 || bus.retired !== 16'd1
        || bus.retired !== e.retired) begin
      errors++;
      $display("FAIL fetch_dbg got ipc %0d ret %0d exp 3 1",
               bus.inst_pc, bus.retired);
    end
    checks++;
    if (bus.addr !== 5'd3) begin
      errors++;
      $display("FAIL fetch_addr_pc got %0d exp 3", bus.addr);
    end
    bus.sel = 1'b0;
    #1;
    checks++;
    if (bus.addr !== 5'd17) begin
      errors++;
      $display("FAIL fetch_addr_op got %0d exp 17", bus.addr);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] st [3] = '{5'd31, 5'd30, 5'd31};
    logic [1:0] inc [3] = '{2'd1, 2'd2, 2'd2};
    logic [4:0] ex [3] = '{5'd0, 5'd0, 5'd1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      goto_pc(st[i]);
      cyc(1'b1, 1'b0, 1'b0, inc[i], 1'b0, 1'b0, 8'd0);
      e = q.pop_front();
      checks++;
      if (bus.pc !== ex[i] || bus.pc !== e.pc) begin
        errors++;
        $display("FAIL wrap_%0d got %0d exp %0d",
                 i, bus.pc, ex[i]);
      end
      checks++;
      if (bus.seq_err !== 1'b0) begin
        errors++;
        $display("FAIL wrap_err_%0d got %b exp 0",
                 i, bus.seq_err);
      end
    end
  endtask

  task automatic test_jump();
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'hff);
    e = q.pop_front();
    checks++;
    if (bus.seq_err !== 1'b1 || bus.opcode !== OP_SKZ
        || bus.retired !== 16'd0) begin
      errors++;
      $display("FAIL ldir_nord got err %b op %0d ret %0d exp 1 1 0",
               bus.seq_err, bus.opcode, bus.retired);
    end
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, {OP_ADD, 5'd9});
    e = q.pop_front();
    checks++;
    if (bus.seq_err !== 1'b0) begin
      errors++;
      $display("FAIL jump_pre got %b exp 0", bus.seq_err);
    end
    cyc(1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 8'd0);
    e = q.pop_front();
    checks++;
    if (bus.pc !== 5'd9 || bus.seq_err !== 1'b1) begin
      errors++;
      $display("FAIL jump_prio got %0d/%b exp 9/1",
               bus.pc, bus.seq_err);
    end
    do_reset();
    idle(0);
    cyc(1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 8'd0);
    e = q.pop_front();
    cyc(1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 8'd0);
    e = q.pop_front();
    checks++;
    if (bus.pc !== 5'd1 || bus.seq_err !== 1'b1) begin
      errors++;
      $display("FAIL inc3 got %0d/%b exp 1/1",
               bus.pc, bus.seq_err);
    end
  endtask

  task automatic test_halt();
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, {OP_ADD, 5'd6});
    e = q.pop_front();
    cyc(1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, {OP_XOR, 5'd2});
    e = q.pop_front();
    checks++;
    if (bus.halted !== 1'b1 || bus.pc !== 5'd1) begin
      errors++;
      $display("FAIL halt_set got %b/%0d exp 1/1",
               bus.halted, bus.pc);
    end
    checks++;
    if (bus.opcode !== OP_ADD || bus.retired !== 16'd1) begin
      errors++;
      $display("FAIL halt_ir got %0d/%0d exp %0d/1",
               bus.opcode, bus.retired, OP_ADD);
    end
    cyc(1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, {OP_XOR, 5'd2});
    e = q.pop_front();
    checks++;
    if (bus.halted !== 1'b1 || bus.pc !== e.pc
        || bus.operand !== 5'd6 || bus.retired !== 16'd1) begin
      errors++;
      $display("FAIL halt_frozen got %b pc %0d opd %0d ret %0d",
               bus.halted, bus.pc, bus.operand, bus.retired);
    end
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);
    e = q.pop_front();
    rst = 1'b0;
    checks++;
    if (bus.halted !== 1'b0 || bus.pc !== 5'd0
        || bus.retired !== 16'd0) begin
      errors++;
      $display("FAIL halt_clear got %b/%0d/%0d exp 0/0/0",
               bus.halted, bus.pc, bus.retired);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 8'd0);
    e = q.pop_front();
    cyc(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, {OP_ADD, 5'd4});
    e = q.pop_front();
    cyc(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, {OP_XOR, 5'd20});
    e = q.pop_front();
    checks++;
    if (bus.pc !== 5'd4 || bus.operand !== 5'd20) begin
      errors++;
      $display("FAIL same_cyc got pc %0d opd %0d exp 4 20",
               bus.pc, bus.operand);
    end
    checks++;
    if (bus.inst_pc !== 5'd2 || bus.retired !== 16'd2) begin
      errors++;
      $display("FAIL same_dbg got ipc %0d ret %0d exp 2 2",
               bus.inst_pc, bus.retired);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ip;
    logic       lp;
    logic       li;
    logic       r;
    logic       h;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      ip = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) ip = 2'd3;
      lp = ($urandom_range(0, 5) == 0);
      li = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 7) != 0);
      h  = (i == 50);
      cyc(1'($urandom_range(0, 1)), r, li, ip, lp, h,
          8'($urandom));
      e = q.pop_front();
      checks++;
      if (bus.pc !== e.pc || bus.inst_pc !== e.inst_pc
          || {bus.opcode, bus.operand} !== e.ir
          || bus.retired !== e.retired
          || bus.halted !== e.halted
          || bus.seq_err !== e.seq_err) begin
        errors++;
        $display("FAIL b2b_%0d got pc %0d ipc %0d ir %h ret %0d h %b e %b exp %0d %0d %h %0d %b %b",
                 i, bus.pc, bus.inst_pc,
                 {bus.opcode, bus.operand}, bus.retired,
                 bus.halted, bus.seq_err, e.pc, e.inst_pc,
                 e.ir, e.retired, e.halted, e.seq_err);
      end
      checks++;
      if (bus.addr !== (bus.sel ? e.pc : e.ir[4:0])) begin
        errors++;
        $display("FAIL b2b_addr_%0d got %0d sel %b",
                 i, bus.addr, bus.sel);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    m_pc = 5'd0;
    m_inst = 5'd0;
    m_ir = 8'd0;
    m_ret = 16'd0;
    m_halt = 1'b0;
    m_err = 1'b0;
    bus.sel = 1'b1;
    bus.rd = 1'b0;
    bus.ld_ir = 1'b0;
    bus.inc_pc = 2'd0;
    bus.ld_pc = 1'b0;
    bus.halt = 1'b0;
    bus.mem_rdata = 8'd0;
    test_reset();
    test_fetch();
    test_wrap();
    test_jump();
    test_halt();
    test_same_cycle();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
